// File: rtl/coreboard1588_pkg.sv
// coreboard1588_pkg: shared types and widths for the ADS868x scan sequencer.
package coreboard1588_pkg;
  localparam int CH_SEL_W = 3;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_OUTPUT, S_NEXT} scan_state_e;
endpackage

// File: rtl/ads868x_scan_ctrl_if.sv
// ads868x_scan_ctrl_if: conversion handshake to the SPI master and result stream to capture.
interface ads868x_scan_ctrl_if import coreboard1588_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic conv_req, conv_ack, res_valid, res_ready, res_last;
  logic [DATA_W-1:0] conv_data, res_data;
  logic [CH_SEL_W-1:0] res_ch;
  modport master (output conv_req, res_valid, res_data, res_ch, res_last,
                  input conv_ack, conv_data, res_ready);
  modport slave (input conv_req, res_valid, res_data, res_ch, res_last,
                 output conv_ack, conv_data, res_ready);
endinterface

// File: rtl/ads868x_ch_pick.sv
// ads868x_ch_pick: lowest set mask bit above cur_i, or from bit 0 when first_i.
module ads868x_ch_pick import coreboard1588_pkg::*; #(parameter int NUM_CH = 8) (
  input  logic [NUM_CH-1:0]   mask_i,
  input  logic [CH_SEL_W-1:0] cur_i,
  input  logic                first_i,
  output logic [CH_SEL_W-1:0] nxt_o,
  output logic                found_o,
  output logic                is_last_o
);
  always_comb begin
    nxt_o = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask_i[i] && (first_i || i > int'(cur_i))) begin
        nxt_o = CH_SEL_W'(i);
        found_o = 1'b1;
      end
  end
  assign is_last_o = ~found_o;
endmodule

// File: rtl/ads868x_scan_ctrl.sv
// ads868x_scan_ctrl: steps the ADS868x mux through a channel mask and streams tagged conversions.
// Define SCAN_TIMEOUT_EN to add the conversion-ack timeout (TIMEOUT_CYC) and err_timeout.
module ads868x_scan_ctrl import coreboard1588_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = DEF_DATA_W
`ifdef SCAN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NUM_CH-1:0]   cfg_ch_mask,
  input  logic [15:0]         cfg_settle,
  input  logic                cfg_continuous,
  input  logic                ctrl_start,
  input  logic                ctrl_abort,
  input  logic                trig_in,
  output logic [CH_SEL_W-1:0] ch_sel,
  output logic                mux_en,
  output logic                busy,
  output logic                scan_done,
  output logic                trig_miss,
  output logic [15:0]         scan_cnt,
  output logic                err_timeout,
  ads868x_scan_ctrl_if.master bus
);
  scan_state_e state_q, state_d;
  logic [CH_SEL_W-1:0] cur_q, cur_d, nxt_q, nxt_d, ch_sel_q, ch_sel_d, res_ch_q, res_ch_d, pk_nxt;
  logic [NUM_CH-1:0] mask_q, mask_d, pk_mask;
  logic [15:0] cnt_q, cnt_d, scan_cnt_q, scan_cnt_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic last_q, last_d, mux_en_q, mux_en_d, conv_req_q, conv_req_d, res_valid_q, res_valid_d;
  logic res_last_q, res_last_d, busy_q, busy_d, done_q, done_d, miss_q, miss_d, err_q, err_d;
  logic trig_q, start, pk_first, pk_found, pk_is_last;
`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  assign start = ctrl_start | (trig_in & ~trig_q);
  // In CONVERT the picker looks ahead in the snapshot; elsewhere it finds the first channel of cfg_ch_mask
  assign pk_first = state_q != S_CONVERT;
  assign pk_mask = pk_first ? cfg_ch_mask : mask_q;
  ads868x_ch_pick #(.NUM_CH(NUM_CH)) u_pick (
    .mask_i(pk_mask), .cur_i(cur_q), .first_i(pk_first),
    .nxt_o(pk_nxt), .found_o(pk_found), .is_last_o(pk_is_last)
  );
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    nxt_d = nxt_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    last_d = last_q;
    ch_sel_d = ch_sel_q;
    mux_en_d = mux_en_q;
    conv_req_d = conv_req_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    res_ch_d = res_ch_q;
    res_last_d = res_last_q;
    scan_cnt_d = scan_cnt_q;
    err_d = err_q;
    done_d = 1'b0;
    miss_d = start && state_q != S_IDLE && !ctrl_abort;
`ifdef SCAN_TIMEOUT_EN
    tmo_d = state_q == S_CONVERT ? tmo_q + TW'(1) : '0;
`endif
    case (state_q)
      S_IDLE: if (start && pk_found) begin
        mask_d = cfg_ch_mask;
        cur_d = pk_nxt;
        err_d = 1'b0;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        ch_sel_d = cur_q;
        mux_en_d = 1'b1;
        cnt_d = cfg_settle;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (cnt_q == 16'd0) begin
        conv_req_d = 1'b1;
        state_d = S_CONVERT;
      end else cnt_d = cnt_q - 16'd1;
      S_CONVERT: begin
        nxt_d = pk_nxt;
        last_d = pk_is_last;
        if (bus.conv_ack) begin
          conv_req_d = 1'b0;
          res_valid_d = 1'b1;
          res_data_d = bus.conv_data;
          res_ch_d = cur_q;
          res_last_d = pk_is_last;
          state_d = S_OUTPUT;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          conv_req_d = 1'b0;
          err_d = 1'b1;
          state_d = S_NEXT;
        end
`endif
      end
      S_OUTPUT: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d = S_NEXT;
      end
      S_NEXT: if (!last_q) begin
        cur_d = nxt_q;
        state_d = S_SELECT;
      end else begin
        done_d = 1'b1;
        scan_cnt_d = scan_cnt_q + 16'd1;
        if (cfg_continuous && pk_found) begin
          mask_d = cfg_ch_mask;
          cur_d = pk_nxt;
          state_d = S_SELECT;
        end else begin
          mux_en_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ctrl_abort) begin
      state_d = S_IDLE;
      conv_req_d = 1'b0;
      res_valid_d = 1'b0;
      mux_en_d = 1'b0;
      done_d = 1'b0;
      scan_cnt_d = scan_cnt_q;
      err_d = err_q;
    end
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge aclk)
    if (!aresetn) begin
      state_q <= S_IDLE;
      cur_q <= '0;
      nxt_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      last_q <= 1'b0;
      ch_sel_q <= '0;
      mux_en_q <= 1'b0;
      conv_req_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_ch_q <= '0;
      res_last_q <= 1'b0;
      scan_cnt_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      miss_q <= 1'b0;
      busy_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      ch_sel_q <= ch_sel_d;
      mux_en_q <= mux_en_d;
      conv_req_q <= conv_req_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_ch_q <= res_ch_d;
      res_last_q <= res_last_d;
      scan_cnt_q <= scan_cnt_d;
      err_q <= err_d;
      done_q <= done_d;
      miss_q <= miss_d;
      busy_q <= busy_d;
      trig_q <= trig_in;
    end
`ifdef SCAN_TIMEOUT_EN
  always_ff @(posedge aclk) tmo_q <= !aresetn ? '0 : tmo_d;
`endif
  assign ch_sel = ch_sel_q;
  assign mux_en = mux_en_q;
  assign busy = busy_q;
  assign scan_done = done_q;
  assign trig_miss = miss_q;
  assign scan_cnt = scan_cnt_q;
  assign err_timeout = err_q;
  assign bus.conv_req = conv_req_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_ch = res_ch_q;
  assign bus.res_last = res_last_q;
endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// tb_ads868x_scan_ctrl: scoreboard bench; the reference expands each started mask into its ordered result list.
module tb_ads868x_scan_ctrl;
  import coreboard1588_pkg::*;
  logic clk = 1'b0, aresetn = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] cfg_ch_mask = '0;
  logic [15:0] cfg_settle = '0;
  logic cfg_continuous = 1'b0, ctrl_start = 1'b0, ctrl_abort = 1'b0, trig_in = 1'b0;
  logic [2:0] ch_sel;
  logic mux_en, busy, scan_done, trig_miss, err_timeout;
  logic [15:0] scan_cnt;
  ads868x_scan_ctrl_if #(.DATA_W(16)) bus ();
  ads868x_scan_ctrl #(
    .NUM_CH(8), .DATA_W(16)
`ifdef SCAN_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .aclk(clk), .aresetn(aresetn), .cfg_ch_mask(cfg_ch_mask), .cfg_settle(cfg_settle),
    .cfg_continuous(cfg_continuous), .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
    .trig_in(trig_in), .ch_sel(ch_sel), .mux_en(mux_en), .busy(busy), .scan_done(scan_done),
    .trig_miss(trig_miss), .scan_cnt(scan_cnt), .err_timeout(err_timeout), .bus(bus)
  );
  typedef struct packed {logic [2:0] ch; logic last;} exp_t;
  exp_t exp_q[$];
  logic [15:0] data_q[$];
  int checks = 0, errors = 0, done_cnt = 0, miss_cnt = 0, exp_passes = 0, cyc = 0;
  int cur_settle = 0, fixed_delay = -1;
  logic ack_inhibit = 1'b0, skip_ch1 = 1'b0, hold_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: one result per set bit, ascending, last flag on the highest set bit.
  task automatic push_pass(input logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i]) exp_q.push_back('{ch: 3'(i), last: (m >> (i + 1)) == 8'd0});
    exp_passes++;
  endtask

  task automatic pulse_start(input bit use_trig);
    @(posedge clk); #1;
    if (use_trig) trig_in = 1'b1; else ctrl_start = 1'b1;
    @(posedge clk); #1;
    trig_in = 1'b0;
    ctrl_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 ctrl_abort = 1'b1;
    @(posedge clk); #1 ctrl_abort = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 4000);
    chk(nm, busy, 0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
    chk("done_reached", done_cnt >= target, 1);
  endtask

  // SPI master model: acks each request after a delay with a random word.
  initial begin
    int d;
    bus.conv_ack = 1'b0;
    bus.conv_data = '0;
    forever begin
      @(negedge clk);
      if (aresetn && bus.conv_req === 1'b1 && !ack_inhibit && !(skip_ch1 && ch_sel == 3'd1)) begin
        d = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(0, 8));
        repeat (d) @(posedge clk);
        #1;
        if (bus.conv_req) begin
          bus.conv_ack = 1'b1;
          bus.conv_data = 16'($urandom);
          data_q.push_back(bus.conv_data);
          @(posedge clk); #1 bus.conv_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: result scoreboard, hold stability, pulse counters, settle latency.
  logic prev_v = 1'b0, prev_acc = 1'b0, prev_last = 1'b0, prev_mux = 1'b0, prev_req = 1'b0, pend = 1'b0;
  logic [15:0] prev_d = '0;
  logic [2:0] prev_ch = '0;
  int mux_rise = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (aresetn) begin
      if (prev_v && !prev_acc) begin
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_data", bus.res_data, prev_d);
        chk("hold_ch", bus.res_ch, prev_ch);
        chk("hold_last", bus.res_last, prev_last);
      end
      if (bus.res_valid && bus.res_ready) begin
        chk("exp_avail", exp_q.size() != 0, 1);
        chk("data_avail", data_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("res_ch", bus.res_ch, exp_q[0].ch);
          chk("res_last", bus.res_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
        if (data_q.size() != 0) chk("res_data", bus.res_data, data_q.pop_front());
      end
      if (scan_done) done_cnt++;
      if (trig_miss) miss_cnt++;
      if (mux_en && !prev_mux) begin mux_rise = cyc; pend = 1'b1; end
      if (bus.conv_req && !prev_req && pend) begin
        chk("settle_latency", cyc - mux_rise, cur_settle + 1);
        pend = 1'b0;
      end
      prev_v = bus.res_valid;
      prev_acc = bus.res_valid && bus.res_ready;
      prev_d = bus.res_data;
      prev_ch = bus.res_ch;
      prev_last = bus.res_last;
      prev_mux = mux_en;
      prev_req = bus.conv_req;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, base, mbase;
    logic [7:0] m;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_mux_en", mux_en, 0);
    chk("rst_conv_req", bus.conv_req, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_ch", bus.res_ch, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_trig_miss", trig_miss, 0);
    chk("rst_scan_cnt", scan_cnt, 0);
    chk("rst_err_timeout", err_timeout, 0);

    // Two-channel single pass with fixed ack delay
    cfg_ch_mask = 8'h05; cfg_settle = 16'd3; cur_settle = 3; fixed_delay = 10;
    base = done_cnt;
    push_pass(8'h05);
    pulse_start(1'b0);
    wait_idle("pass05_idle");
    fixed_delay = -1;
    chk("pass05_scan_cnt", scan_cnt, exp_passes);
    chk("pass05_done", done_cnt - base, 1);
    chk("pass05_mux_off", mux_en, 0);

    // Result held while res_ready is low
    hold_ready = 1'b1; cfg_ch_mask = 8'h03; cfg_settle = 16'd1; cur_settle = 1;
    push_pass(8'h03);
    pulse_start(1'b0);
    n = 0;
    while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
    chk("hold_first_valid", bus.res_valid, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.conv_req) n++;
    end
    chk("hold_no_req", n, 0);
    hold_ready = 1'b0;
    wait_idle("hold_idle");
    chk("hold_scan_cnt", scan_cnt, exp_passes);

    // Continuous single channel, three passes, trigger while busy
    cfg_continuous = 1'b1; cfg_ch_mask = 8'h80; cfg_settle = 16'd2; cur_settle = 2;
    base = done_cnt; mbase = miss_cnt;
    repeat (3) push_pass(8'h80);
    pulse_start(1'b1);
    wait_done(base + 1);
    pulse_start(1'b1);
    wait_done(base + 2);
    cfg_continuous = 1'b0;
    wait_idle("cont_idle");
    chk("cont_scan_cnt", scan_cnt, exp_passes);
    chk("cont_done", done_cnt - base, 3);
    chk("cont_trig_miss", miss_cnt - mbase, 1);

    // Abort during SETTLE
    cfg_ch_mask = 8'h0F; cfg_settle = 16'd20; cur_settle = 20;
    pulse_start(1'b0);
    repeat (4) @(posedge clk);
    pulse_abort();
    @(negedge clk);
    chk("abort_settle_busy", busy, 0);
    chk("abort_settle_mux", mux_en, 0);
    chk("abort_settle_req", bus.conv_req, 0);
    chk("abort_settle_cnt", scan_cnt, exp_passes);

    // Abort during CONVERT
    ack_inhibit = 1'b1; cfg_ch_mask = 8'h06; cfg_settle = 16'd1; cur_settle = 1;
    pulse_start(1'b0);
    n = 0;
    while (!bus.conv_req && n < 100) begin @(negedge clk); n++; end
    chk("abort_conv_req_seen", bus.conv_req, 1);
    pulse_abort();
    @(negedge clk);
    chk("abort_conv_busy", busy, 0);
    chk("abort_conv_mux", mux_en, 0);
    chk("abort_conv_req", bus.conv_req, 0);
    chk("abort_conv_cnt", scan_cnt, exp_passes);
    ack_inhibit = 1'b0;

    // Empty mask: start ignored
    cfg_ch_mask = 8'h00;
    pulse_start(1'b0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || bus.conv_req || mux_en) n++;
    end
    chk("mask0_idle", n, 0);
    chk("mask0_cnt", scan_cnt, exp_passes);

    // Random single passes, start or trigger, mask changed mid-scan
    for (int p = 0; p < 10; p++) begin
      m = 8'($urandom_range(1, 255));
      cfg_ch_mask = m;
      cfg_settle = 16'($urandom_range(0, 5));
      cur_settle = int'(cfg_settle);
      push_pass(m);
      pulse_start(1'($urandom_range(0, 1)));
      cfg_ch_mask = 8'($urandom);
      wait_idle("rand_idle");
      chk("rand_scan_cnt", scan_cnt, exp_passes);
    end

`ifdef SCAN_TIMEOUT_EN
    // Channel 1 never acked: skipped, flag set, pass still completes
    skip_ch1 = 1'b1; cfg_ch_mask = 8'h03; cfg_settle = 16'd1; cur_settle = 1;
    base = done_cnt;
    exp_q.push_back('{ch: 3'd0, last: 1'b0});
    exp_passes++;
    pulse_start(1'b0);
    wait_idle("tmo_idle");
    chk("tmo_err", err_timeout, 1);
    chk("tmo_done", done_cnt - base, 1);
    chk("tmo_scan_cnt", scan_cnt, exp_passes);
    skip_ch1 = 1'b0; cfg_ch_mask = 8'h01;
    push_pass(8'h01);
    pulse_start(1'b0);
    @(negedge clk);
    chk("tmo_err_cleared", err_timeout, 0);
    wait_idle("tmo_idle2");
`else
    chk("err_tied_low", err_timeout, 0);
`endif

    repeat (5) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    chk("data_drained", data_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
